apb_mem_arbiter: RTL and testbench
==================================

APB_MEM_ARBITER -- requirements
Module: apb_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, 4, APB address width.
REQ-002 SHALL have parameter DATA_W, 8, APB data width.
REQ-003 SHALL have parameter TIMEOUT_CYC, 16, maximum ACCESS cycles without PREADY (used only with APB_ARB_TIMEOUT_EN).
REQ-004 SHALL have port clk  input  1  clock, rising edge.
REQ-005 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports req0/req1  input  1  requester transfer request, level.
REQ-007 SHALL have ports wr0/wr1  input  1  requester direction, 1 = write.
REQ-008 SHALL have ports addr0/addr1  input  ADDR_W  requester address.
REQ-009 SHALL have ports wdata0/wdata1  input  DATA_W  requester write data.
REQ-010 SHALL have ports gnt0/gnt1  output  1  one-cycle pulse: command accepted.
REQ-011 SHALL have ports done0/done1  output  1  one-cycle pulse: transfer complete.
REQ-012 SHALL have port rdata  output  DATA_W  read data, valid with done pulse of a read.
REQ-013 SHALL have port err  output  1  timeout flag, valid with done pulse.
REQ-014 SHALL have ports PSEL, PENABLE, PWRITE  output  1  APB master controls.
REQ-015 SHALL have ports PADDR  output  ADDR_W and PWDATA  output  DATA_W  APB address/data.
REQ-016 SHALL have ports PRDATA  input  DATA_W and PREADY  input  1  APB slave response.

Function
REQ-017 SHALL implement FSM IDLE, SETUP, ACCESS; all outputs registered.
REQ-018 SHALL arbitrate only in IDLE, or in ACCESS in the cycle PREADY=1; req ignored in SETUP and in ACCESS while PREADY=0.
REQ-019 SHALL use round-robin: on req0&req1 the requester not granted last wins; single request wins outright.
REQ-020 SHALL, at the arbitration edge, latch winner's wr/addr/wdata into PWRITE/PADDR/PWDATA, enter SETUP, and pulse that requester's gnt in the SETUP cycle.
REQ-021 SHALL drive SETUP: PSEL=1, PENABLE=0; next cycle ACCESS: PSEL=1, PENABLE=1; PADDR/PWRITE/PWDATA stable SETUP through ACCESS.
REQ-022 SHALL remain in ACCESS until PREADY=1 is sampled, inserting wait states indefinitely (unless timeout compiled in).
REQ-023 SHALL, on PREADY=1 in ACCESS: capture PRDATA into rdata if read (rdata otherwise unchanged), pulse owner's done next cycle with err=0, update last-granted.
REQ-024 SHALL, on completion with a pending req, go directly to SETUP (no IDLE bubble); otherwise go IDLE with PSEL=PENABLE=0.
REQ-025 SHALL treat req still high after gnt and sampled at the next arbitration point as a new transfer.
REQ-026 SHALL never assert gnt0 and gnt1, or done0 and done1, in the same cycle.

Reset
REQ-027 SHALL on rstn low force IDLE, PSEL=PENABLE=PWRITE=0, PADDR=0, PWDATA=0, rdata=0, gnt*=done*=err=0, last-granted=1 (req0 wins first tie), timeout counter 0.
REQ-028 SHALL abort any transfer in flight on reset with no done pulse.

Configuration
REQ-029 SHALL, with APB_ARB_TIMEOUT_EN defined, count ACCESS cycles with PREADY=0; at TIMEOUT_CYC, drop PSEL/PENABLE, pulse owner's done with err=1, leave rdata unchanged, rearbitrate as REQ-024.
REQ-030 SHALL, without APB_ARB_TIMEOUT_EN, contain no counter and tie err to 0.

Structure
REQ-031 SHALL place the state enum and ADDR_W/DATA_W defaults in package apb_arb_pkg.
REQ-032 SHALL isolate the two-way round-robin picker in sub-module rr_arb2 (inputs req[1:0], last; outputs grant[1:0]).

Verification
REQ-033 SHALL test: req0=1, wr0=1, addr0=3, wdata0=8'hA5 to mem slave -> gnt0 at cycle+1, PSEL/PENABLE sequence, done0 at cycle+3.
REQ-034 SHALL test: req1 read addr1=3 after REQ-033 -> PREADY one wait state, done1 at cycle+4 with rdata=8'hA5, err=0.
REQ-035 SHALL test: req0 and req1 held high from reset -> grants alternate 0,1,0,1, back-to-back without IDLE cycle.
REQ-036 SHALL test: rstn low during ACCESS -> all outputs reset values next cycle, no done pulse.
REQ-037 SHALL test (APB_ARB_TIMEOUT_EN): slave PREADY tied 0 -> done0 with err=1 after 16 ACCESS cycles, rdata unchanged, PSEL=0.

Source files
------------

// File: rtl/apb_arb_pkg.sv
// ---------------------------------------------------------------------------
// apb_arb_pkg
// Shared types and defaults for the two-requester APB master arbiter.
//   - ADDR_W_DEF / DATA_W_DEF : default APB address / data widths
//   - arb_state_t             : APB master phase (IDLE, SETUP, ACCESS)
//   - onehot_of()             : requester index -> one-hot pulse vector
// ---------------------------------------------------------------------------
package apb_arb_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETUP  = 2'b01,
        ST_ACCESS = 2'b10
    } arb_state_t;

    // Requester index (0/1) to its one-hot gnt/done position.
    function automatic logic [1:0] onehot_of(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/apb_mem_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin picker, purely combinational.
//   req[1:0]   : pending requests
//   last       : index of the requester served most recently
//   grant[1:0] : one-hot winner (all zero when nothing is requested)
// A lone request always wins; on a tie the requester not served last wins.
// ---------------------------------------------------------------------------
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    // Winner selection
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/apb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// apb_mem_arbiter
// Shares one APB master port between two requesters with round-robin
// arbitration. All outputs are registered.
//   clk, rstn              : clock (rising edge), async active-low reset
//   req/wr/addr/wdata 0,1  : requester commands (req is level sensitive)
//   gnt0/gnt1              : one-cycle pulse in SETUP, command accepted
//   done0/done1            : one-cycle pulse after the transfer completes
//   rdata, err             : read data / timeout flag, valid with done
//   PSEL..PWDATA, PRDATA, PREADY : APB master interface
// Optional build macro APB_ARB_TIMEOUT_EN: aborts an ACCESS phase after
// TIMEOUT_CYC wait states and reports it via err. Without the macro there
// is no counter and err is constant 0.
// ---------------------------------------------------------------------------
module apb_mem_arbiter
    import apb_arb_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req0,
    input  logic              req1,
    input  logic              wr0,
    input  logic              wr1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY
);

    arb_state_t        state_r, state_nxt_s;
    logic              psel_r, psel_nxt_s;
    logic              penable_r, penable_nxt_s;
    logic              pwrite_r, pwrite_nxt_s;
    logic [ADDR_W-1:0] paddr_r, paddr_nxt_s;
    logic [DATA_W-1:0] pwdata_r, pwdata_nxt_s;
    logic [DATA_W-1:0] rdata_r, rdata_nxt_s;
    logic [1:0]        gnt_r, gnt_nxt_s;
    logic [1:0]        done_r, done_nxt_s;
    logic              owner_r, owner_nxt_s;
    logic              last_r, last_nxt_s;
    logic [1:0]        grant_s;
    logic              last_eff_s;
    logic              tmo_s;
    logic              xfer_end_s;
    logic              arb_en_s;

    assign xfer_end_s = (state_r == ST_ACCESS) && (PREADY || tmo_s);
    assign arb_en_s   = (state_r == ST_IDLE) || xfer_end_s;
    // last_r is only refreshed at the completion edge, so when rearbitrating
    // on that same edge the current owner is the requester served last.
    assign last_eff_s = (state_r == ST_ACCESS) ? owner_r : last_r;

    rr_arb2 u_rr (
        .req   ({req1, req0}),
        .last  (last_eff_s),
        .grant (grant_s)
    );

`ifdef APB_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt_r;
    logic             err_r;

    assign tmo_s = (state_r == ST_ACCESS) && !PREADY &&
                   (tmo_cnt_r == TMO_W'(TIMEOUT_CYC - 1));

    // Wait-state counter for the current ACCESS phase and registered err
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tmo_cnt_r <= {TMO_W{1'b0}};
            err_r     <= 1'b0;
        end else begin
            err_r <= tmo_s;
            if ((state_r == ST_ACCESS) && !PREADY && !tmo_s) begin
                tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
            end else begin
                tmo_cnt_r <= {TMO_W{1'b0}};
            end
        end
    end

    assign err = err_r;
`else
    assign tmo_s = 1'b0;
    assign err   = 1'b0;
`endif

    // Next-state and next-output decode
    always_comb begin
        state_nxt_s   = state_r;
        psel_nxt_s    = psel_r;
        penable_nxt_s = penable_r;
        pwrite_nxt_s  = pwrite_r;
        paddr_nxt_s   = paddr_r;
        pwdata_nxt_s  = pwdata_r;
        rdata_nxt_s   = rdata_r;
        gnt_nxt_s     = 2'b00;
        done_nxt_s    = 2'b00;
        owner_nxt_s   = owner_r;
        last_nxt_s    = last_r;

        // Completion: report to the owner; only a successful read updates rdata
        if (xfer_end_s) begin
            done_nxt_s = onehot_of(owner_r);
            last_nxt_s = owner_r;
            if (PREADY && !pwrite_r) begin
                rdata_nxt_s = PRDATA;
            end else begin
                rdata_nxt_s = rdata_r;
            end
        end else begin
            done_nxt_s = 2'b00;
        end

        case (state_r)
            ST_IDLE, ST_ACCESS: begin
                if (arb_en_s) begin
                    if (grant_s != 2'b00) begin
                        state_nxt_s   = ST_SETUP;
                        psel_nxt_s    = 1'b1;
                        penable_nxt_s = 1'b0;
                        gnt_nxt_s     = grant_s;
                        owner_nxt_s   = grant_s[1];
                        pwrite_nxt_s  = grant_s[1] ? wr1    : wr0;
                        paddr_nxt_s   = grant_s[1] ? addr1  : addr0;
                        pwdata_nxt_s  = grant_s[1] ? wdata1 : wdata0;
                    end else begin
                        state_nxt_s   = ST_IDLE;
                        psel_nxt_s    = 1'b0;
                        penable_nxt_s = 1'b0;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_SETUP: begin
                state_nxt_s   = ST_ACCESS;
                psel_nxt_s    = 1'b1;
                penable_nxt_s = 1'b1;
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                psel_nxt_s    = 1'b0;
                penable_nxt_s = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r   <= ST_IDLE;
            psel_r    <= 1'b0;
            penable_r <= 1'b0;
            pwrite_r  <= 1'b0;
            paddr_r   <= {ADDR_W{1'b0}};
            pwdata_r  <= {DATA_W{1'b0}};
            rdata_r   <= {DATA_W{1'b0}};
            gnt_r     <= 2'b00;
            done_r    <= 2'b00;
            owner_r   <= 1'b0;
            last_r    <= 1'b1;
        end else begin
            state_r   <= state_nxt_s;
            psel_r    <= psel_nxt_s;
            penable_r <= penable_nxt_s;
            pwrite_r  <= pwrite_nxt_s;
            paddr_r   <= paddr_nxt_s;
            pwdata_r  <= pwdata_nxt_s;
            rdata_r   <= rdata_nxt_s;
            gnt_r     <= gnt_nxt_s;
            done_r    <= done_nxt_s;
            owner_r   <= owner_nxt_s;
            last_r    <= last_nxt_s;
        end
    end

    assign PSEL    = psel_r;
    assign PENABLE = penable_r;
    assign PWRITE  = pwrite_r;
    assign PADDR   = paddr_r;
    assign PWDATA  = pwdata_r;
    assign rdata   = rdata_r;
    assign gnt0    = gnt_r[0];
    assign gnt1    = gnt_r[1];
    assign done0   = done_r[0];
    assign done1   = done_r[1];

endmodule

// File: tb/tb_apb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_apb_mem_arbiter
// Self-checking bench for apb_mem_arbiter with a small APB memory slave.
// Expected completions are queued when a request is driven and compared
// when done0/done1 pulses. Inputs are driven and outputs sampled on the
// falling clock edge.
// ---------------------------------------------------------------------------
module tb_apb_mem_arbiter;

    logic       clk, rstn;
    logic       req0, req1, wr0, wr1;
    logic [3:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       gnt0, gnt1, done0, done1, err;
    logic [7:0] rdata;
    logic       PSEL, PENABLE, PWRITE, PREADY;
    logic [3:0] PADDR;
    logic [7:0] PWDATA, PRDATA;

    apb_mem_arbiter dut (
        .clk(clk), .rstn(rstn),
        .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata(rdata), .err(err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory slave: ws_cfg wait states per access, tie0 holds PREADY low
    logic [7:0] mem [16];
    int         ws_cfg;
    logic       tie0;
    int         ws_cnt;

    assign PRDATA = mem[PADDR];
    assign PREADY = PSEL && PENABLE && !tie0 && (ws_cnt >= ws_cfg);

    always @(posedge clk) begin
        if (PSEL && PENABLE && PREADY && PWRITE) mem[PADDR] <= PWDATA;
        if (PSEL && PENABLE && !PREADY) ws_cnt <= ws_cnt + 1;
        else ws_cnt <= 0;
    end

    typedef struct packed {
        logic       who;
        logic       is_rd;
        logic [7:0] rdata;
        logic       err;
    } exp_t;

    exp_t sb_q[$];
    logic gq[$];
    int   tests_run = 0;
    int   failed    = 0;
    int   cyc       = 0;

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    // Pop the oldest expected completion and compare with the current done
    task automatic sb_pop_compare(input string tag);
        exp_t e;
        tests_run++;
        if (sb_q.size() == 0) begin
            failed++;
            $display("FAIL %s_sb_empty: unexpected done0=%0b done1=%0b", tag, done0, done1);
        end else begin
            e = sb_q.pop_front();
            if ({done1, done0} !== (e.who ? 2'b10 : 2'b01)) begin
                failed++;
                $display("FAIL %s_done_who: got {done1,done0}=%b, want requester %0d", tag, {done1, done0}, e.who);
            end
            tests_run++;
            if (err !== e.err) begin
                failed++;
                $display("FAIL %s_err: got %0b, want %0b", tag, err, e.err);
            end
            if (e.is_rd) begin
                tests_run++;
                if (rdata !== e.rdata) begin
                    failed++;
                    $display("FAIL %s_rdata: got %h, want %h", tag, rdata, e.rdata);
                end
            end
        end
    endtask

    // Wait (bounded) for a done pulse, check its latency and scoreboard entry
    task automatic wait_done(input string tag, input int t0, input int lat);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (done0 || done1) seen = 1'b1;
            else tick();
        end
        tests_run++;
        if (!seen) begin
            failed++;
            $display("FAIL %s_no_done: no done pulse within 40 cycles", tag);
        end else begin
            if ((cyc - t0) != lat) begin
                failed++;
                $display("FAIL %s_latency: done at cycle+%0d, want cycle+%0d", tag, cyc - t0, lat);
            end
            sb_pop_compare(tag);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        tick();
        tick();
        tests_run++;
        if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, rdata, gnt0, gnt1, done0, done1, err} !== 29'd0) begin
            failed++;
            $display("FAIL reset_outputs: got %h, want 0",
                     {PSEL, PENABLE, PWRITE, PADDR, PWDATA, rdata, gnt0, gnt1, done0, done1, err});
        end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_write();
        int t0;
        ws_cfg = 0;
        req0 = 1'b1; wr0 = 1'b1; addr0 = 4'd3; wdata0 = 8'hA5;
        sb_q.push_back('{who: 1'b0, is_rd: 1'b0, rdata: 8'h00, err: 1'b0});
        t0 = cyc;
        tick();
        req0 = 1'b0;
        tests_run++;
        if ({gnt1, gnt0, PSEL, PENABLE} !== 4'b0110) begin
            failed++;
            $display("FAIL write_setup: got {gnt1,gnt0,PSEL,PENABLE}=%b, want 0110", {gnt1, gnt0, PSEL, PENABLE});
        end
        tests_run++;
        if ({PWRITE, PADDR, PWDATA} !== {1'b1, 4'd3, 8'hA5}) begin
            failed++;
            $display("FAIL write_cmd: got %h, want %h", {PWRITE, PADDR, PWDATA}, {1'b1, 4'd3, 8'hA5});
        end
        tick();
        tests_run++;
        if ({PSEL, PENABLE, gnt0, done0} !== 4'b1100) begin
            failed++;
            $display("FAIL write_access: got {PSEL,PENABLE,gnt0,done0}=%b, want 1100", {PSEL, PENABLE, gnt0, done0});
        end
        wait_done("write", t0, 3);
        tests_run++;
        if ({PSEL, PENABLE} !== 2'b00) begin
            failed++;
            $display("FAIL write_idle: got {PSEL,PENABLE}=%b, want 00", {PSEL, PENABLE});
        end
        tick();
    endtask

    task automatic test_read_wait();
        int t0;
        ws_cfg = 1;
        req1 = 1'b1; wr1 = 1'b0; addr1 = 4'd3;
        sb_q.push_back('{who: 1'b1, is_rd: 1'b1, rdata: 8'hA5, err: 1'b0});
        t0 = cyc;
        tick();
        req1 = 1'b0;
        tests_run++;
        if ({gnt1, gnt0, PSEL, PENABLE, PWRITE, PADDR} !== {5'b10100, 4'd3}) begin
            failed++;
            $display("FAIL read_setup: got %b, want %b", {gnt1, gnt0, PSEL, PENABLE, PWRITE, PADDR}, {5'b10100, 4'd3});
        end
        tick();
        tick();
        tests_run++;
        if ({PSEL, PENABLE, done1} !== 3'b110) begin
            failed++;
            $display("FAIL read_wait_state: got {PSEL,PENABLE,done1}=%b, want 110", {PSEL, PENABLE, done1});
        end
        wait_done("read", t0, 4);
        tick();
        ws_cfg = 0;
    endtask

    task automatic test_back_to_back();
        int   grants = 0;
        int   dones  = 0;
        logic prev_pen = 1'b0;
        logic g;
        rstn = 1'b0;
        req0 = 1'b1; wr0 = 1'b1; addr0 = 4'd5; wdata0 = 8'h3C;
        req1 = 1'b1; wr1 = 1'b0; addr1 = 4'd5;
        for (int k = 0; k < 4; k++) begin
            gq.push_back(k[0]);
            sb_q.push_back('{who: k[0], is_rd: k[0], rdata: 8'h3C, err: 1'b0});
        end
        tick();
        rstn = 1'b1;
        for (int i = 0; i < 30 && dones < 4; i++) begin
            tick();
            if (gnt0 || gnt1) begin
                tests_run++;
                if (gnt0 && gnt1) begin
                    failed++;
                    $display("FAIL b2b_gnt_both: gnt0 and gnt1 high together");
                end else if (gq.size() == 0) begin
                    failed++;
                    $display("FAIL b2b_gnt_extra: got gnt1=%0b, want no grant", gnt1);
                end else begin
                    g = gq.pop_front();
                    if (gnt1 !== g) begin
                        failed++;
                        $display("FAIL b2b_order: got grant to %0d, want %0d", gnt1, g);
                    end
                end
                if (grants > 0) begin
                    tests_run++;
                    if (prev_pen !== 1'b1) begin
                        failed++;
                        $display("FAIL b2b_bubble: SETUP not preceded by ACCESS (PENABLE=%0b)", prev_pen);
                    end
                end
                grants++;
                if (grants == 4) begin
                    req0 = 1'b0;
                    req1 = 1'b0;
                end
            end
            if (done0 || done1) begin
                tests_run++;
                if (done0 && done1) begin
                    failed++;
                    $display("FAIL b2b_done_both: done0 and done1 high together");
                end
                sb_pop_compare("b2b");
                dones++;
            end
            prev_pen = PENABLE;
        end
        tests_run++;
        if (grants != 4 || dones != 4) begin
            failed++;
            $display("FAIL b2b_count: got %0d grants %0d dones, want 4 and 4", grants, dones);
        end
        tick();
        tests_run++;
        if (PSEL !== 1'b0) begin
            failed++;
            $display("FAIL b2b_idle: got PSEL=%0b, want 0", PSEL);
        end
    endtask

    task automatic test_reset_access();
        int extra = 0;
        ws_cfg = 8;
        req0 = 1'b1; wr0 = 1'b1; addr0 = 4'd9; wdata0 = 8'h77;
        tick();
        req0 = 1'b0;
        tick();
        tests_run++;
        if ({PSEL, PENABLE} !== 2'b11) begin
            failed++;
            $display("FAIL rst_acc_in_access: got {PSEL,PENABLE}=%b, want 11", {PSEL, PENABLE});
        end
        #1 rstn = 1'b0;
        tick();
        tests_run++;
        if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, rdata, gnt0, gnt1, done0, done1, err} !== 29'd0) begin
            failed++;
            $display("FAIL rst_acc_outputs: got %h, want 0",
                     {PSEL, PENABLE, PWRITE, PADDR, PWDATA, rdata, gnt0, gnt1, done0, done1, err});
        end
        rstn = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done0 || done1 || PSEL) extra++;
        end
        tests_run++;
        if (extra != 0) begin
            failed++;
            $display("FAIL rst_acc_no_done: got %0d cycles with done/PSEL, want 0", extra);
        end
        ws_cfg = 0;
    endtask

`ifdef APB_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int t0;
        // Normal read first so rdata holds a known non-zero value
        req1 = 1'b1; wr1 = 1'b0; addr1 = 4'd3;
        sb_q.push_back('{who: 1'b1, is_rd: 1'b1, rdata: 8'hA5, err: 1'b0});
        t0 = cyc;
        tick();
        req1 = 1'b0;
        wait_done("tmo_pre", t0, 3);
        tick();
        tie0 = 1'b1;
        req0 = 1'b1; wr0 = 1'b0; addr0 = 4'd5;
        sb_q.push_back('{who: 1'b0, is_rd: 1'b1, rdata: 8'hA5, err: 1'b1});
        t0 = cyc;
        tick();
        req0 = 1'b0;
        wait_done("timeout", t0, 18);
        tests_run++;
        if ({PSEL, PENABLE} !== 2'b00) begin
            failed++;
            $display("FAIL timeout_psel: got {PSEL,PENABLE}=%b, want 00", {PSEL, PENABLE});
        end
        tick();
        tie0 = 1'b0;
    endtask
`endif

    initial begin
        rstn = 1'b0;
        req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
        addr0 = 4'd0; addr1 = 4'd0; wdata0 = 8'd0; wdata1 = 8'd0;
        ws_cfg = 0;
        tie0 = 1'b0;
        test_reset();
        test_write();
        test_read_wait();
        test_back_to_back();
        test_reset_access();
`ifdef APB_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
